instruction_block_loader: RTL and testbench
===========================================

Name: instruction_block_loader

Overview:
- Producer side of the 16-word instruction bundle interface consumed by the fetch stage.
- Issues line-sized (512-bit) memory reads for consecutive program blocks and unpacks each response into 16 x 32-bit instructions.
- Presents each block to the fetch stage with a one-cycle instrVld pulse.
- Stops after the last block, or after delivering a block that contains a halt instruction.

Parameters:
- ADDR_W, 42, width of memory line address.
- NUM_BLOCKS, 256, maximum blocks per program (4096 instructions / 16).

Ports:
- clk  input  1  clock
- rst  input  1  synchronous active-high reset
- start  input  1  pulse; begin loading a program at base_addr
- base_addr  input  ADDR_W  line address of block 0, sampled on accepted start
- blk_req  input  1  pulse from fetch stage requesting the next block
- mem_req_valid  output  1  read request valid
- mem_req_ready  input  1  memory accepts request
- mem_req_addr  output  ADDR_W  line address of request
- mem_rsp_valid  input  1  read data valid
- mem_rsp_data  input  512  read data line
- instrVld  output  1  one-cycle pulse; instructionsOut holds a new block
- instructionsOut  output  32x16  unpacked block; word i = mem_rsp_data[32*i+31:32*i]
- busy  output  1  high from accepted start until DONE/IDLE
- done  output  1  high in DONE state
- rsp_err  output  1  sticky; response received while no request outstanding

Behaviour:
- All state changes on posedge clk. rst is synchronous, active-high, and has priority over all other inputs in the same cycle.
- Reset values:
  - FSM = IDLE.
  - mem_req_valid, instrVld, busy, done, rsp_err = 0.
  - mem_req_addr = 0; blk_idx = 0; pending = 0.
  - Every instructionsOut word = {4'b0110, 28'b0}.
- FSM states: IDLE, REQ, WAIT, LOAD, READY, DONE.
- IDLE: on start, latch base_addr, set blk_idx=0 and busy=1, go to REQ.
- REQ: mem_req_valid=1 with mem_req_addr = base + blk_idx, both held stable until mem_req_ready. The transfer completes in the cycle valid&ready; next state WAIT.
- WAIT: on mem_rsp_valid, capture all 16 words into instructionsOut, go to LOAD.
- LOAD: instrVld=1 for exactly this cycle.
  - Go to DONE if the captured block has any word with bits[30] and [29] both set (halt), or if blk_idx == NUM_BLOCKS-1.
  - Otherwise increment blk_idx and go to READY.
- READY: on blk_req, or if pending is set, clear pending and go to REQ.
- DONE: done=1, busy=0, instructionsOut held. start re-enters the load sequence exactly as from IDLE, clearing done.
- Latency: start to mem_req_valid = 1 cycle. mem_rsp_valid to instrVld = 1 cycle. blk_req in READY to mem_req_valid = 1 cycle.
- blk_req handling:
  - A blk_req in REQ, WAIT or LOAD sets pending, so the request is not lost.
  - blk_req in IDLE or DONE is ignored.
  - Multiple blk_req pulses before READY collapse into one.
- start while busy is ignored, as is start in the same cycle as rst.
- mem_rsp_valid in any state other than WAIT:
  - The data is ignored and rsp_err is set.
  - rsp_err is cleared only by rst or an accepted start.
- Ordering: one request outstanding at most; no out-of-order handling is needed.
- mem_req_addr arithmetic is modulo 2^ADDR_W; base + blk_idx wraps silently.
- instructionsOut changes only on capture in WAIT and is stable at all other times.

Test Plan:
- Basic block: rst, then start with base_addr=0x100. Bench sees mem_req_addr=0x100 and returns a line with word i = i+1. Required: instrVld pulse 1 cycle later, instructionsOut[0]=1, instructionsOut[15]=16, state READY.
- Back-pressure: hold mem_req_ready=0 for 5 cycles. Required: mem_req_valid stays 1 and mem_req_addr stays 0x100 throughout. After ready, exactly one request is accepted.
- Sequential blocks: after the first block, pulse blk_req three times with responses. Required: addresses 0x101, 0x102, 0x103 in order, and three instrVld pulses.
- Halt stop: block 2 word 7 = 0x6000_0000. Required: instrVld for that block, then done=1, busy=0, and no further mem_req_valid despite blk_req.
- Pending request: pulse blk_req during WAIT of block 0. Required: a block 1 request is issued 1 cycle after entering READY, without a further blk_req.
- End/error/reset:
  - NUM_BLOCKS=4 reaches DONE after the 4th block.
  - A stray mem_rsp_valid in READY sets rsp_err without changing instructionsOut.
  - rst asserted mid-WAIT returns all outputs to their reset values the next cycle.

Source files
------------

// File: rtl/instruction_block_loader.sv
// Fetches consecutive 512-bit program lines from memory and hands each one to the
// fetch stage as sixteen 32-bit instructions, stopping at the last block or on a halt.
module instruction_block_loader #(
    parameter int ADDR_W     = 42,
    parameter int NUM_BLOCKS = 256
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   start,
    input  logic [ADDR_W-1:0]      base_addr,
    input  logic                   blk_req,
    output logic                   mem_req_valid,
    input  logic                   mem_req_ready,
    output logic [ADDR_W-1:0]      mem_req_addr,
    input  logic                   mem_rsp_valid,
    input  logic [511:0]           mem_rsp_data,
    output logic                   instrVld,
    output logic [15:0][31:0]      instructionsOut,
    output logic                   busy,
    output logic                   done,
    output logic                   rsp_err
);

    localparam int IDX_W = (NUM_BLOCKS > 1) ? $clog2(NUM_BLOCKS) : 1;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_REQ   = 3'd1,
        S_WAIT  = 3'd2,
        S_LOAD  = 3'd3,
        S_READY = 3'd4,
        S_DONE  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [IDX_W-1:0]       blk_idx_q, blk_idx_d;
    logic                   pending_q, pending_d;
    logic [ADDR_W-1:0]      addr_q, addr_d;
    logic [15:0][31:0]      instr_q, instr_d;
    logic                   req_valid_q, req_valid_d;
    logic                   vld_q, vld_d;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;
    logic                   rsp_err_q, rsp_err_d;

    logic                   start_acc_s;
    logic                   halt_s;
    logic                   last_blk_s;

    // A halt is any word with bits 30 and 29 both set.
    function automatic logic block_has_halt(input logic [15:0][31:0] blk);
        logic hit;
        hit = 1'b0;
        for (int i = 0; i < 16; i++) begin
            hit = hit | (blk[i][30] & blk[i][29]);
        end
        return hit;
    endfunction

    assign start_acc_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign halt_s      = block_has_halt(instr_q);
    assign last_blk_s  = (blk_idx_q == IDX_W'(NUM_BLOCKS - 1));

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = start ? S_REQ : S_IDLE;
            S_REQ:   state_d = mem_req_ready ? S_WAIT : S_REQ;
            S_WAIT:  state_d = mem_rsp_valid ? S_LOAD : S_WAIT;
            S_LOAD:  state_d = (halt_s || last_blk_s) ? S_DONE : S_READY;
            S_READY: state_d = (blk_req || pending_q) ? S_REQ : S_READY;
            S_DONE:  state_d = start ? S_REQ : S_DONE;
            default: state_d = S_IDLE;
        endcase
    end

    // Output and datapath next values; outputs are registered from the next state.
    always_comb begin
        base_d      = start_acc_s ? base_addr : base_q;

        if (start_acc_s) begin
            blk_idx_d = {IDX_W{1'b0}};
        end else if ((state_q == S_LOAD) && (state_d == S_READY)) begin
            blk_idx_d = blk_idx_q + {{(IDX_W-1){1'b0}}, 1'b1};
        end else begin
            blk_idx_d = blk_idx_q;
        end

        // blk_req arriving while a block is in flight is remembered for READY.
        if (start_acc_s || (state_q == S_READY)) begin
            pending_d = 1'b0;
        end else if (blk_req && ((state_q == S_REQ) || (state_q == S_WAIT) || (state_q == S_LOAD))) begin
            pending_d = 1'b1;
        end else begin
            pending_d = pending_q;
        end

        if (start_acc_s) begin
            addr_d = base_addr;
        end else if ((state_q == S_READY) && (state_d == S_REQ)) begin
            addr_d = base_q + ADDR_W'(blk_idx_q);
        end else begin
            addr_d = addr_q;
        end

        instr_d = ((state_q == S_WAIT) && mem_rsp_valid) ? mem_rsp_data : instr_q;

        if (start_acc_s) begin
            rsp_err_d = 1'b0;
        end else if (mem_rsp_valid && (state_q != S_WAIT)) begin
            rsp_err_d = 1'b1;
        end else begin
            rsp_err_d = rsp_err_q;
        end

        req_valid_d = (state_d == S_REQ);
        vld_d       = (state_d == S_LOAD);
        busy_d      = (state_d != S_IDLE) && (state_d != S_DONE);
        done_d      = (state_d == S_DONE);
    end

    // Datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            base_q      <= {ADDR_W{1'b0}};
            blk_idx_q   <= {IDX_W{1'b0}};
            pending_q   <= 1'b0;
            addr_q      <= {ADDR_W{1'b0}};
            instr_q     <= {16{32'h6000_0000}};
            req_valid_q <= 1'b0;
            vld_q       <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rsp_err_q   <= 1'b0;
        end else begin
            base_q      <= base_d;
            blk_idx_q   <= blk_idx_d;
            pending_q   <= pending_d;
            addr_q      <= addr_d;
            instr_q     <= instr_d;
            req_valid_q <= req_valid_d;
            vld_q       <= vld_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rsp_err_q   <= rsp_err_d;
        end
    end

    assign mem_req_valid   = req_valid_q;
    assign mem_req_addr    = addr_q;
    assign instrVld        = vld_q;
    assign instructionsOut = instr_q;
    assign busy            = busy_q;
    assign done            = done_q;
    assign rsp_err         = rsp_err_q;

endmodule

// File: tb/tb_instruction_block_loader.sv
// Directed bench for instruction_block_loader built with a 4-block program limit
// so the end-of-program path is reached quickly.
module tb_instruction_block_loader;

    localparam int ADDR_W = 42;

    logic               clk;
    logic               rst;
    logic               start;
    logic [ADDR_W-1:0]  base_addr;
    logic               blk_req;
    logic               mem_req_valid;
    logic               mem_req_ready;
    logic [ADDR_W-1:0]  mem_req_addr;
    logic               mem_rsp_valid;
    logic [511:0]       mem_rsp_data;
    logic               instrVld;
    logic [15:0][31:0]  instructionsOut;
    logic               busy;
    logic               done;
    logic               rsp_err;

    int n_checks;
    int n_pass;

    instruction_block_loader #(.ADDR_W(ADDR_W), .NUM_BLOCKS(4)) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .base_addr       (base_addr),
        .blk_req         (blk_req),
        .mem_req_valid   (mem_req_valid),
        .mem_req_ready   (mem_req_ready),
        .mem_req_addr    (mem_req_addr),
        .mem_rsp_valid   (mem_rsp_valid),
        .mem_rsp_data    (mem_rsp_data),
        .instrVld        (instrVld),
        .instructionsOut (instructionsOut),
        .busy            (busy),
        .done            (done),
        .rsp_err         (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    function automatic logic [511:0] make_block(input logic [31:0] first, input int halt_idx);
        logic [511:0] b;
        for (int i = 0; i < 16; i++) begin
            b[32*i +: 32] = (i == halt_idx) ? 32'h6000_0000 : first + 32'(i);
        end
        return b;
    endfunction

    // Expects a request already presented; accepts it, answers it, checks the delivery.
    task automatic serve(input string tag, input logic [ADDR_W-1:0] exp_addr, input logic [511:0] data);
        check({tag, "_req_valid"}, 64'(mem_req_valid), 64'd1);
        check({tag, "_req_addr"}, 64'(mem_req_addr), 64'(exp_addr));
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check({tag, "_one_accept"}, 64'(mem_req_valid), 64'd0);
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = data;
        tick();
        mem_rsp_valid = 1'b0;
        check({tag, "_vld"}, 64'(instrVld), 64'd1);
        check({tag, "_w0"}, 64'(instructionsOut[0]), 64'(data[31:0]));
        check({tag, "_w7"}, 64'(instructionsOut[7]), 64'(data[255:224]));
        check({tag, "_w15"}, 64'(instructionsOut[15]), 64'(data[511:480]));
        tick();
        check({tag, "_vld_pulse"}, 64'(instrVld), 64'd0);
    endtask

    task automatic pulse_blk_req();
        blk_req = 1'b1;
        tick();
        blk_req = 1'b0;
    endtask

    initial begin
        n_checks      = 0;
        n_pass        = 0;
        rst           = 1'b1;
        start         = 1'b1;
        base_addr     = 42'h0AA;
        blk_req       = 1'b0;
        mem_req_ready = 1'b0;
        mem_rsp_valid = 1'b0;
        mem_rsp_data  = 512'd0;
        tick();
        start = 1'b0;
        tick();
        rst = 1'b0;
        tick();
        check("rst_valid", 64'(mem_req_valid), 64'd0);
        check("rst_vld", 64'(instrVld), 64'd0);
        check("rst_busy", 64'(busy), 64'd0);
        check("rst_done", 64'(done), 64'd0);
        check("rst_err", 64'(rsp_err), 64'd0);
        check("rst_addr", 64'(mem_req_addr), 64'd0);
        check("rst_w0", 64'(instructionsOut[0]), 64'h6000_0000);
        check("rst_w15", 64'(instructionsOut[15]), 64'h6000_0000);

        // Block 0 with back-pressure, plus two blk_req pulses during WAIT.
        start     = 1'b1;
        base_addr = 42'h100;
        tick();
        start = 1'b0;
        check("start_valid", 64'(mem_req_valid), 64'd1);
        check("start_addr", 64'(mem_req_addr), 64'h100);
        check("start_busy", 64'(busy), 64'd1);
        for (int k = 0; k < 5; k++) begin
            tick();
            check("bp_valid", 64'(mem_req_valid), 64'd1);
            check("bp_addr", 64'(mem_req_addr), 64'h100);
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("bp_one_accept", 64'(mem_req_valid), 64'd0);
        pulse_blk_req();
        pulse_blk_req();
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = make_block(32'd1, 16);
        tick();
        mem_rsp_valid = 1'b0;
        check("b0_vld", 64'(instrVld), 64'd1);
        check("b0_w0", 64'(instructionsOut[0]), 64'd1);
        check("b0_w15", 64'(instructionsOut[15]), 64'd16);
        tick();
        check("b0_ready_vld", 64'(instrVld), 64'd0);
        check("b0_ready_valid", 64'(mem_req_valid), 64'd0);
        check("b0_ready_busy", 64'(busy), 64'd1);
        tick();
        serve("b1", 42'h101, make_block(32'h1000, 16));
        tick();
        check("collapse_no_req", 64'(mem_req_valid), 64'd0);

        // Stray response in READY, then start while busy.
        mem_rsp_valid = 1'b1;
        mem_rsp_data  = make_block(32'h7000, 16);
        tick();
        mem_rsp_valid = 1'b0;
        check("stray_err", 64'(rsp_err), 64'd1);
        check("stray_w0", 64'(instructionsOut[0]), 64'h1000);
        check("stray_vld", 64'(instrVld), 64'd0);
        start     = 1'b1;
        base_addr = 42'h999;
        tick();
        start = 1'b0;
        check("busy_start_ignored", 64'(mem_req_valid), 64'd0);

        pulse_blk_req();
        serve("b2", 42'h102, make_block(32'h2000, 16));
        pulse_blk_req();
        serve("b3", 42'h103, make_block(32'h3000, 16));
        check("end_done", 64'(done), 64'd1);
        check("end_busy", 64'(busy), 64'd0);
        check("end_err_sticky", 64'(rsp_err), 64'd1);
        pulse_blk_req();
        tick();
        check("end_no_req", 64'(mem_req_valid), 64'd0);
        check("end_hold_w0", 64'(instructionsOut[0]), 64'h3000);

        // Restart from DONE at the top of the address space; halt in block 2.
        start     = 1'b1;
        base_addr = 42'h3FF_FFFF_FFFF;
        tick();
        start = 1'b0;
        check("re_done", 64'(done), 64'd0);
        check("re_busy", 64'(busy), 64'd1);
        check("re_err_clr", 64'(rsp_err), 64'd0);
        serve("h0", 42'h3FF_FFFF_FFFF, make_block(32'h4000, 16));
        pulse_blk_req();
        serve("h1_wrap", 42'h0, make_block(32'h5000, 16));
        pulse_blk_req();
        serve("h2", 42'h1, make_block(32'h0800, 7));
        check("halt_done", 64'(done), 64'd1);
        check("halt_busy", 64'(busy), 64'd0);
        pulse_blk_req();
        check("halt_no_req0", 64'(mem_req_valid), 64'd0);
        tick();
        check("halt_no_req1", 64'(mem_req_valid), 64'd0);

        // Reset during WAIT after a stray response in REQ.
        start     = 1'b1;
        base_addr = 42'h200;
        tick();
        start = 1'b0;
        check("r_addr", 64'(mem_req_addr), 64'h200);
        mem_rsp_valid = 1'b1;
        tick();
        mem_rsp_valid = 1'b0;
        check("r_stray_err", 64'(rsp_err), 64'd1);
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_valid", 64'(mem_req_valid), 64'd0);
        check("mid_rst_vld", 64'(instrVld), 64'd0);
        check("mid_rst_busy", 64'(busy), 64'd0);
        check("mid_rst_done", 64'(done), 64'd0);
        check("mid_rst_err", 64'(rsp_err), 64'd0);
        check("mid_rst_addr", 64'(mem_req_addr), 64'd0);
        check("mid_rst_w0", 64'(instructionsOut[0]), 64'h6000_0000);
        check("mid_rst_w7", 64'(instructionsOut[7]), 64'h6000_0000);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
